// File: rtl/soc_system_vec_pkg.sv
// Shared definitions for the vector sequencer: CSR map, bit positions,
// lane operation encodings and the sequencer state type.
package soc_system_vec_pkg;

  // LEN register width: holds 0..63 so out-of-range requests are visible.
  localparam int LEN_W = 6;

  // CSR word offsets
  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_LEN    = 2'd1;
  localparam logic [1:0] CSR_STATUS = 2'd2;
  localparam logic [1:0] CSR_CYCLES = 2'd3;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_OP_LSB = 1;
  localparam int CTRL_IE     = 3;

  // STATUS bit positions
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A run is legal only for 1..depth words.
  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int depth);
    return (len != '0) && (int'(len) <= depth);
  endfunction

endpackage

// File: rtl/soc_system_vec_sequencer_if.sv
// Avalon-MM style CSR bus between HPS (master) and the sequencer (slave).
// Read data is combinational, valid in the same cycle as read.
interface soc_system_vec_sequencer_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/soc_system_vec_lane_alu.sv
// One 32-bit lane of the element-wise operation. Purely combinational;
// results wrap modulo 2**LANE_W with no carry to neighbouring lanes.
module soc_system_vec_lane_alu
  import soc_system_vec_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  op_e               op,
  output logic [LANE_W-1:0] y
);

  // Select the lane operation.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/soc_system_vec_sequencer.sv
// Streams words 0..LEN-1 from the arg_x/arg_y RAM ports through two lane
// ALUs into the result RAM, under control of a 4-register CSR block.
module soc_system_vec_sequencer
  import soc_system_vec_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int LANE_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  soc_system_vec_sequencer_if.slave  csr,
  output logic                       irq,
  output logic [ADDR_W-1:0]          x_address,
  output logic                       x_chipselect,
  input  logic [DATA_W-1:0]          x_readdata,
  output logic [ADDR_W-1:0]          y_address,
  output logic                       y_chipselect,
  input  logic [DATA_W-1:0]          y_readdata,
  output logic [ADDR_W-1:0]          r_address,
  output logic                       r_chipselect,
  output logic                       r_write,
  output logic [DATA_W-1:0]          r_writedata,
  output logic [7:0]                 r_byteenable
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e             state;
  state_e             state_next;
  logic [LEN_W-1:0]   len;
  op_e                op;
  logic               ie;
  logic               done;
  logic               err;
  logic [31:0]        cycles;
  logic [ADDR_W-1:0]  rd_idx;
  logic [ADDR_W-1:0]  wr_idx;
  logic               wr_valid;
  logic [DATA_W-1:0]  result;

  logic busy;
  logic ctrl_wr;
  logic len_wr;
  logic status_wr;
  logic start_req;
  logic start_ok;
  logic start_bad;
  logic last_issue;
  logic unused_wdata;

  assign busy       = (state != ST_IDLE);
  assign ctrl_wr    = csr.write && (csr.address == CSR_CTRL);
  assign len_wr     = csr.write && (csr.address == CSR_LEN);
  assign status_wr  = csr.write && (csr.address == CSR_STATUS);
  assign start_req  = ctrl_wr && csr.writedata[CTRL_START];
  assign start_ok   = start_req && !busy && len_ok(len, DEPTH);
  assign start_bad  = start_req && !busy && !len_ok(len, DEPTH);
  assign last_issue = (state == ST_RUN) && (LEN_W'(rd_idx) == len - LEN_W'(1));
  assign irq        = done && ie;
  assign unused_wdata = ^csr.writedata[31:LEN_W];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: IDLE -> RUN on accepted START, RUN -> DRAIN after last issue.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok)   state_next = ST_RUN;
      ST_RUN:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // RAM port outputs: reads while in RUN, writes one cycle behind each read.
  always_comb begin
    x_address    = '0;
    y_address    = '0;
    x_chipselect = 1'b0;
    y_chipselect = 1'b0;
    if (state == ST_RUN) begin
      x_address    = rd_idx;
      y_address    = rd_idx;
      x_chipselect = 1'b1;
      y_chipselect = 1'b1;
    end
    r_write      = wr_valid;
    r_chipselect = wr_valid;
    r_address    = wr_valid ? wr_idx : '0;
    r_writedata  = wr_valid ? result : '0;
    r_byteenable = wr_valid ? 8'hFF : 8'h00;
  end

  // Read-index counter and the one-stage write pipeline (index + valid).
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx   <= '0;
      wr_idx   <= '0;
      wr_valid <= 1'b0;
    end else begin
      wr_valid <= (state == ST_RUN);
      wr_idx   <= rd_idx;
      if (start_ok)
        rd_idx <= '0;
      else if (state == ST_RUN && !last_issue)
        rd_idx <= rd_idx + ADDR_W'(1);
    end
  end

  // Lane ALUs operate directly on the RAM read data, which arrives in the write cycle.
  soc_system_vec_lane_alu #(.LANE_W(LANE_W)) u_alu_lo (
    .a  (x_readdata[LANE_W-1:0]),
    .b  (y_readdata[LANE_W-1:0]),
    .op (op),
    .y  (result[LANE_W-1:0])
  );

  soc_system_vec_lane_alu #(.LANE_W(LANE_W)) u_alu_hi (
    .a  (x_readdata[DATA_W-1:LANE_W]),
    .b  (y_readdata[DATA_W-1:LANE_W]),
    .op (op),
    .y  (result[DATA_W-1:LANE_W])
  );

  // CSR registers; later assignments take priority (set over W1C, START over all).
  always_ff @(posedge clk) begin
    if (reset) begin
      len    <= '0;
      op     <= OP_ADD;
      ie     <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      cycles <= '0;
    end else begin
      if (ctrl_wr)
        ie <= csr.writedata[CTRL_IE];
      if (ctrl_wr && !busy)
        op <= op_e'(csr.writedata[CTRL_OP_LSB +: 2]);
      if (len_wr && !busy)
        len <= csr.writedata[LEN_W-1:0];
      if (status_wr && csr.writedata[STATUS_DONE])
        done <= 1'b0;
      if (status_wr && csr.writedata[STATUS_ERR])
        err <= 1'b0;
      if (state == ST_DRAIN)
        done <= 1'b1;
      if (start_bad)
        err <= 1'b1;
      if (start_ok) begin
        done   <= 1'b0;
        err    <= 1'b0;
        cycles <= '0;
      end else if (busy) begin
        cycles <= cycles + 32'd1;
      end
    end
  end

  // Combinational read mux; START always reads back as 0.
  always_comb begin
    csr.readdata = '0;
    if (csr.read) begin
      case (csr.address)
        CSR_CTRL:   csr.readdata = {28'd0, ie, op, 1'b0};
        CSR_LEN:    csr.readdata = {{(32-LEN_W){1'b0}}, len};
        CSR_STATUS: csr.readdata = {29'd0, err, done, busy};
        CSR_CYCLES: csr.readdata = cycles;
        default:    csr.readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_vec_sequencer.sv
// Scoreboard bench: stimulus pushes expected RAM issues and result writes,
// a monitor on the falling edge pops and compares whatever the DUT presents.
module tb_soc_system_vec_sequencer;
  import soc_system_vec_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int LANE_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  soc_system_vec_sequencer_if csr_bus ();

  logic              irq;
  logic [ADDR_W-1:0] x_address, y_address, r_address;
  logic              x_chipselect, y_chipselect, r_chipselect, r_write;
  logic [DATA_W-1:0] x_readdata, y_readdata, r_writedata;
  logic [7:0]        r_byteenable;

  logic [DATA_W-1:0] x_mem [32];
  logic [DATA_W-1:0] y_mem [32];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_wr [$];
  logic [ADDR_W-1:0] exp_iss [$];
  int                busy_cycles = 0;
  int                n_tests = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  soc_system_vec_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .csr          (csr_bus),
    .irq          (irq),
    .x_address    (x_address),
    .x_chipselect (x_chipselect),
    .x_readdata   (x_readdata),
    .y_address    (y_address),
    .y_chipselect (y_chipselect),
    .y_readdata   (y_readdata),
    .r_address    (r_address),
    .r_chipselect (r_chipselect),
    .r_write      (r_write),
    .r_writedata  (r_writedata),
    .r_byteenable (r_byteenable)
  );

  // Source RAMs with one-cycle read latency.
  always @(posedge clk) begin
    if (x_chipselect) x_readdata <= x_mem[x_address];
    if (y_chipselect) y_readdata <= y_mem[y_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    csr_bus.address   = addr;
    csr_bus.writedata = data;
    csr_bus.write     = 1'b1;
    @(negedge clk);
    csr_bus.write     = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    csr_bus.address = addr;
    csr_bus.read    = 1'b1;
    #1;
    data = csr_bus.readdata;
    csr_bus.read = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(addr, v);
    check(name, 64'(v), 64'(exp));
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] st;
    int n = 0;
    csr_read(CSR_STATUS, st);
    while (st[STATUS_BUSY] && n < 200) begin
      csr_read(CSR_STATUS, st);
      n++;
    end
    check({name, "_finished"}, 64'(st[STATUS_BUSY]), 64'd0);
  endtask

  task automatic expect_word(input int i, input logic [DATA_W-1:0] data);
    wr_t w;
    w.addr = ADDR_W'(i);
    w.data = data;
    exp_iss.push_back(ADDR_W'(i));
    exp_wr.push_back(w);
  endtask

  // Monitor: compares every issue and every result write against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (x_chipselect || r_write) busy_cycles++;
      if (x_chipselect) begin
        logic [63:0] e_addr;
        e_addr = 'x;
        if (exp_iss.size() > 0) e_addr = 64'(exp_iss.pop_front());
        check("issue_x_addr", 64'(x_address), e_addr);
        check("issue_y_match", 64'({y_chipselect, y_address}), 64'({1'b1, x_address}));
      end else begin
        check("rd_idle", 64'({y_chipselect, x_address, y_address}), 64'd0);
      end
      if (r_write) begin
        logic [63:0] e_addr;
        logic [63:0] e_data;
        e_addr = 'x;
        e_data = 'x;
        if (exp_wr.size() > 0) begin
          wr_t w;
          w = exp_wr.pop_front();
          e_addr = 64'(w.addr);
          e_data = w.data;
        end
        check("wr_addr", 64'(r_address), e_addr);
        check("wr_data", r_writedata, e_data);
        check("wr_strobes", 64'({r_chipselect, r_byteenable}), 64'h1FF);
      end else begin
        check("wr_idle_data", r_writedata, 64'd0);
        check("wr_idle_ctl", 64'({r_chipselect, r_address, r_byteenable}), 64'd0);
      end
    end
  end

  // Hard stop in case something wedges the stimulus thread.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_bus.address   = '0;
    csr_bus.write     = 1'b0;
    csr_bus.writedata = '0;
    csr_bus.read      = 1'b0;
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = '0;
      y_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    read_check("rst_ctrl",   CSR_CTRL,   32'd0);
    read_check("rst_len",    CSR_LEN,    32'd0);
    read_check("rst_status", CSR_STATUS, 32'd0);
    read_check("rst_cycles", CSR_CYCLES, 32'd0);
    check("rst_irq", 64'(irq), 64'd0);

    // 1) LEN=4 add: r[i] = {i+10, i+20}
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = {32'(i), 32'(i)};
      y_mem[i] = {32'd10, 32'd20};
    end
    csr_write(CSR_LEN, 32'd4);
    for (int i = 0; i < 4; i++) expect_word(i, {32'(i) + 32'd10, 32'(i) + 32'd20});
    busy_cycles = 0;
    csr_write(CSR_CTRL, 32'h1);
    wait_idle("t1");
    check("t1_busy_cycles", 64'(busy_cycles), 64'd5);
    read_check("t1_status", CSR_STATUS, 32'h2);
    read_check("t1_cycles", CSR_CYCLES, 32'd5);
    read_check("t1_ctrl",   CSR_CTRL,   32'd0);

    // 2) LEN=1 sub: {0,5} - {1,7} = {FFFFFFFF, FFFFFFFE}
    x_mem[0] = {32'd0, 32'd5};
    y_mem[0] = {32'd1, 32'd7};
    csr_write(CSR_STATUS, 32'h2);
    csr_write(CSR_LEN, 32'd1);
    expect_word(0, 64'hFFFF_FFFF_FFFF_FFFE);
    busy_cycles = 0;
    csr_write(CSR_CTRL, 32'h3);
    wait_idle("t2");
    check("t2_busy_cycles", 64'(busy_cycles), 64'd2);
    read_check("t2_cycles", CSR_CYCLES, 32'd2);

    // 3) LEN=32 xor with IE: full depth, ends at address 31
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = {32'(i), 32'hFFFF_0000};
      y_mem[i] = {32'hA5A5_A5A5, 32'(i) << 4};
      expect_word(i, {32'(i) ^ 32'hA5A5_A5A5, 32'hFFFF_0000 ^ (32'(i) << 4)});
    end
    csr_write(CSR_STATUS, 32'h2);
    check("t3_irq_before", 64'(irq), 64'd0);
    csr_write(CSR_LEN, 32'd32);
    busy_cycles = 0;
    csr_write(CSR_CTRL, 32'hF);
    wait_idle("t3");
    check("t3_busy_cycles", 64'(busy_cycles), 64'd33);
    read_check("t3_cycles", CSR_CYCLES, 32'd33);
    read_check("t3_ctrl", CSR_CTRL, 32'hE);
    check("t3_irq_done", 64'(irq), 64'd1);
    csr_write(CSR_STATUS, 32'h2);
    check("t3_irq_cleared", 64'(irq), 64'd0);

    // 4) Illegal LEN values raise err and never start
    csr_write(CSR_LEN, 32'd0);
    busy_cycles = 0;
    csr_write(CSR_CTRL, 32'h1);
    read_check("t4_len0_status", CSR_STATUS, 32'h4);
    csr_write(CSR_STATUS, 32'h4);
    read_check("t4_err_w1c", CSR_STATUS, 32'h0);
    csr_write(CSR_LEN, 32'd33);
    read_check("t4_len33_readback", CSR_LEN, 32'd33);
    csr_write(CSR_CTRL, 32'h1);
    read_check("t4_len33_status", CSR_STATUS, 32'h4);
    repeat (3) @(negedge clk);
    check("t4_no_strobes", 64'(busy_cycles), 64'd0);
    check("t4_irq", 64'(irq), 64'd0);
    csr_write(CSR_STATUS, 32'h4);
    read_check("t4_err_w1c2", CSR_STATUS, 32'h0);

    // 5) Writes during a run are ignored; AND keeps running with LEN=6
    for (int i = 0; i < 6; i++) begin
      x_mem[i] = {32'hF0F0_0000 | 32'(i), 32'h1234_5678};
      y_mem[i] = {32'hFFFF_00FF, 32'h0F0F_0F0F};
      expect_word(i, {32'hF0F0_0000 | 32'(i), 32'h0204_0608});
    end
    csr_write(CSR_LEN, 32'd6);
    busy_cycles = 0;
    csr_write(CSR_CTRL, 32'h5);
    csr_write(CSR_CTRL, 32'h1);
    csr_write(CSR_LEN, 32'd2);
    wait_idle("t5");
    check("t5_busy_cycles", 64'(busy_cycles), 64'd7);
    read_check("t5_status", CSR_STATUS, 32'h2);
    read_check("t5_len", CSR_LEN, 32'd6);
    read_check("t5_ctrl", CSR_CTRL, 32'h4);
    // START while done=1: new run begins and done drops immediately
    for (int i = 0; i < 6; i++)
      expect_word(i, {32'hF0F0_0000 | 32'(i), 32'h0204_0608});
    csr_write(CSR_CTRL, 32'h5);
    read_check("t5_restart_status", CSR_STATUS, 32'h1);
    csr_write(CSR_STATUS, 32'h2);
    wait_idle("t5b");
    read_check("t5b_status", CSR_STATUS, 32'h2);

    // 6) Reset during RUN cycle 3 of an LEN=8 run
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = {32'(i), 32'(i)};
      y_mem[i] = {32'd10, 32'd20};
    end
    csr_write(CSR_LEN, 32'd8);
    for (int i = 0; i < 3; i++) exp_iss.push_back(ADDR_W'(i));
    for (int i = 0; i < 2; i++) begin
      wr_t w;
      w.addr = ADDR_W'(i);
      w.data = {32'(i) + 32'd10, 32'(i) + 32'd20};
      exp_wr.push_back(w);
    end
    csr_write(CSR_CTRL, 32'h9);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_outputs", 64'({irq, x_chipselect, y_chipselect, r_write, r_chipselect,
                             x_address, y_address, r_address, r_byteenable}), 64'd0);
    check("t6_wdata", r_writedata, 64'd0);
    reset = 1'b0;
    read_check("t6_status", CSR_STATUS, 32'd0);
    read_check("t6_ctrl",   CSR_CTRL,   32'd0);
    read_check("t6_len",    CSR_LEN,    32'd0);
    read_check("t6_cycles", CSR_CYCLES, 32'd0);
    check("t6_iss_left", 64'(exp_iss.size()), 64'd0);
    check("t6_wr_left",  64'(exp_wr.size()), 64'd0);
    // Fresh run after reset: LEN=3 add
    csr_write(CSR_LEN, 32'd3);
    for (int i = 0; i < 3; i++) expect_word(i, {32'(i) + 32'd10, 32'(i) + 32'd20});
    busy_cycles = 0;
    csr_write(CSR_CTRL, 32'h1);
    wait_idle("t6b");
    check("t6b_busy_cycles", 64'(busy_cycles), 64'd4);
    read_check("t6b_status", CSR_STATUS, 32'h2);
    read_check("t6b_cycles", CSR_CYCLES, 32'd4);

    repeat (3) @(negedge clk);
    check("sb_iss_left", 64'(exp_iss.size()), 64'd0);
    check("sb_wr_left",  64'(exp_wr.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
